// File: rtl/seq_mul32.sv
// seq_mul32: multi-cycle 32x32->64 unsigned shift-add multiplier with valid/ready on both sides.
// Ports: clk, rst_n | in_valid/in_ready/in_a/in_b | out_valid/out_ready/out_prod | busy.
// Optional: SEQ_MUL32_EARLY_TERM_EN ends the loop once no multiplier bits remain.
module seq_mul32 #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] out_prod,
  output logic              busy
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("seq_mul32: only XLEN=32 is supported");
  end
  if (CNT_W < 6) begin : g_bad_cnt
    $error("seq_mul32: CNT_W must hold 0..32");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
`ifdef SEQ_MUL32_EARLY_TERM_EN
  logic [XLEN-1:0]   mrem_q, mrem_d;
  logic [CNT_W:0]    shamt;
`endif

  logic [XLEN-1:0] add_sum;
  logic [XLEN-1:0] sum;
  logic            cout;
  logic            last;
  logic            fin;

  // Kogge-Stone lookahead; only carries into bits 1..31 are formed,
  // the adder has no carry-out.
  function automatic logic [XLEN-1:0] cla32(
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic            c_in
  );
    logic [XLEN-1:0] p;
    logic [XLEN-1:0] c;
    logic [XLEN-2:0] gg;
    logic [XLEN-2:0] pp;
    p  = a ^ b;
    gg = a[XLEN-2:0] & b[XLEN-2:0];
    pp = p[XLEN-2:0];
    for (int d = 1; d < XLEN; d = d * 2) begin
      for (int i = XLEN - 2; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    c[0] = c_in;
    for (int i = 1; i < XLEN; i++) begin
      c[i] = gg[i-1] | (pp[i-1] & c_in);
    end
    return p ^ c;
  endfunction

  // Carry-out rebuilt from the operand MSBs and the sum MSB.
  always_comb begin
    add_sum = cla32(acc_q, mcand_q, 1'b0);
    sum     = lo_q[0] ? add_sum : acc_q;
    cout    = lo_q[0] &
              ((acc_q[XLEN-1] & mcand_q[XLEN-1]) |
               ((acc_q[XLEN-1] ^ mcand_q[XLEN-1]) &
                ~add_sum[XLEN-1]));
  end

  assign last = (cnt_q == CNT_W'(XLEN - 1));

`ifdef SEQ_MUL32_EARLY_TERM_EN
  assign shamt = (CNT_W+1)'(XLEN) - {1'b0, cnt_q};
  assign fin   = last | (mrem_q == '0);
`else
  assign fin   = last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = S_BUSY;
      S_BUSY: if (fin) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_BUSY);
    out_valid = (state_q == S_DONE);
    out_prod  = prod_q;
  end

  always_comb begin
    acc_d   = acc_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`ifdef SEQ_MUL32_EARLY_TERM_EN
    mrem_d  = mrem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d = in_a;
          lo_d    = in_b;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SEQ_MUL32_EARLY_TERM_EN
          mrem_d  = in_b;
`endif
        end
      end
      S_BUSY: begin
`ifdef SEQ_MUL32_EARLY_TERM_EN
        if (mrem_q == '0) begin
          // Remaining partial products are zero: realign and stop.
          prod_d = {acc_q, lo_q} >> shamt;
        end else begin
          mrem_d = mrem_q >> 1;
`endif
          acc_d = {cout, sum[XLEN-1:1]};
          lo_d  = {sum[0], lo_q[XLEN-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (last) prod_d = {acc_d, lo_d};
`ifdef SEQ_MUL32_EARLY_TERM_EN
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
`ifdef SEQ_MUL32_EARLY_TERM_EN
      mrem_q  <= '0;
`endif
    end else begin
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
`ifdef SEQ_MUL32_EARLY_TERM_EN
      mrem_q  <= mrem_d;
`endif
    end
  end

endmodule

// File: doc/seq_mul32.md
Name: seq_mul32

Overview:
- Multi-cycle 32x32 -> 64-bit unsigned shift-add multiplier.
- Feeds the codebase's 32-bit carry-lookahead adder (cla32) once per iteration and consumes its sum.
- Sits on the ALU multiply path, between operand issue and the writeback/result register.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- XLEN, 32, operand width. Only 32 is supported; any other value fails elaboration.
- CNT_W, 6, iteration counter width. Must hold 0..32.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- in_a  input  32  multiplicand.
- in_b  input  32  multiplier.
- out_valid  output  1  product available.
- out_ready  input  1  consumer accepts product.
- out_prod  output  64  unsigned product in_a*in_b.
- busy  output  1  high in BUSY state.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, out_prod=0, internal acc/lo/mcand/cnt=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch mcand=in_a, lo=in_b, acc_hi=0, cnt=0 -> BUSY.
  - BUSY: in_ready=0, busy=1. Perform one iteration per cycle; in_valid is ignored.
  - DONE: out_valid=1, out_prod holds the product. On out_ready -> IDLE.
- Iteration:
  - If lo[0]=1: sum=cla32(acc_hi, mcand, c_in=0). Else sum=acc_hi.
  - cout = acc_hi[31]&mcand[31] | (acc_hi[31]^mcand[31])&~sum[31]. Forced to 0 when lo[0]=0.
  - cout is derived this way because cla32 exposes no carry-out.
  - Update: acc_hi <= {cout, sum[31:1]}; lo <= {sum[0], lo[31:1]}; cnt <= cnt+1.
  - When cnt reaches 32: out_prod <= {acc_hi, lo} (post-update values) -> DONE.
- Latency: acceptance edge plus 32 BUSY edges. out_valid rises 32 cycles after the accept edge.
- Boundaries:
  - DONE with out_ready=1: returns to IDLE. The new operand is accepted no earlier than the next cycle; in_ready=0 in DONE.
  - out_ready low: out_prod and out_valid held stable indefinitely.
  - out_ready asserted in IDLE or BUSY: no effect.
  - Reset asserted in any state: immediately returns to reset values. A partial product is discarded and never presented.
  - Operands may change after acceptance without effect.
- out_prod updates only on entry to DONE. It keeps its last value in IDLE/BUSY (0 after reset).

Optional Feature:
- Macro: SEQ_MUL32_EARLY_TERM_EN.
- When defined:
  - Register mrem = in_b at accept, shifted right 1 per iteration.
  - In BUSY, if mrem==0 and cnt<32, that cycle performs no add. out_prod <= {acc_hi, lo} >> (32-cnt) -> DONE.
  - BUSY cycles: b=0 -> 1; msb index m<31 -> m+2; m=31 -> 32.
- When undefined: mrem does not exist and latency is always 32.
- Product values are identical in both builds.

Test Plan:
- Basic multiply: a=3, b=5, out_ready=1 -> out_prod=0x000000000000000F. out_valid 32 cycles after accept; in_ready=1 the following cycle.
- Carry path: a=0xFFFFFFFF, b=0xFFFFFFFF -> out_prod=0xFFFFFFFE00000001.
- Backpressure: a=0x12345678, b=0x9ABCDEF0, out_ready=0 for 10 cycles after out_valid -> out_prod=0x0B00EA4E242D2080 stable, in_ready=0 throughout. Completes on the out_ready pulse.
- Ignored input and mid-op reset:
  - in_valid pulsed with a=9, b=9 during BUSY -> ignored; the result matches the first operands.
  - Separately, rst_n low at BUSY cycle 10 -> out_valid=0 and in_ready=1 immediately. A subsequent a=2, b=4 yields 8.
- Early termination (macro defined):
  - a=7, b=1 -> out_prod=7 after 2 BUSY cycles.
  - b=0 -> 0 after 1 cycle.
  - a=1, b=0x80000000 -> 0x0000000080000000 after 32 cycles.
  - Without the macro, all three take 32 cycles.
